// File: rtl/pipe_sb_pkg.sv
// Shared types and helpers for the pipeline hazard scoreboard.
// Destination indices are kept beside stage_meta_t so REG_AW can stay a module parameter.
package pipe_sb_pkg;

    localparam int XZR_IDX = 31;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic load;
        logic mul;
    } stage_meta_t;

    function automatic int fsel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_sb_if.sv
// Decode-side bundle of the pipeline scoreboard.
// The master modport is the decode stage; the slave modport is the scoreboard.
interface pipe_sb_if
    import pipe_sb_pkg::*;
#(
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5
);
    localparam int FSW = fsel_w(DEPTH);

    logic                      id_valid;
    logic [REG_AW-1:0]         id_rd;
    logic                      id_regwrite;
    logic                      id_is_load;
    logic                      id_is_mul;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_used;
    logic                      br_taken;
    logic                      stall;
    logic                      flush_if;
    logic [NUM_SRC*FSW-1:0]    fwd_sel;
    logic                      wb_valid;
    logic [REG_AW-1:0]         wb_rd;
    logic [31:0]               stall_cnt;
    logic [31:0]               flush_cnt;

    modport master (
        output id_valid, id_rd, id_regwrite, id_is_load, id_is_mul,
               id_src, id_src_used, br_taken,
        input  stall, flush_if, fwd_sel, wb_valid, wb_rd, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rd, id_regwrite, id_is_load, id_is_mul,
               id_src, id_src_used, br_taken,
        output stall, flush_if, fwd_sel, wb_valid, wb_rd, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_sb_fwd_pick.sv
// Per-source forwarding priority picker: youngest stage whose matching result is usable wins.
// Also flags a match against a load sitting in stage 1, which forces a load-use bubble.
module pipe_sb_fwd_pick
    import pipe_sb_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 5,
    parameter int FSW    = fsel_w(DEPTH)
) (
    input  logic [REG_AW-1:0]             src,
    input  logic                          used,
    input  stage_meta_t [DEPTH-1:0]       meta,
    input  logic [DEPTH-1:0][REG_AW-1:0]  rd,
    output logic [FSW-1:0]                sel,
    output logic                          load_hit
);
    localparam logic [REG_AW-1:0] XZR = REG_AW'(XZR_IDX);

    logic [DEPTH-1:0] hit;
    logic [DEPTH-1:0] avail;

    // Loads and multiplies only have a result once they have left stage 1.
    always_comb begin
        hit   = '0;
        avail = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit[k]   = used && (src != XZR) && meta[k].valid && meta[k].regwrite && (rd[k] == src);
            avail[k] = (k != 0) || !(meta[k].load || meta[k].mul);
        end
    end

    always_comb begin
        sel = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit[k] && avail[k]) sel = FSW'(k + 1);
        end
    end

    assign load_hit = hit[0] && meta[0].load;

endmodule

// File: rtl/pipe_scoreboard.sv
// In-order pipeline scoreboard: load-use stall, forwarding selects, branch flush and event counters.
// Optional macro PIPE_SB_MULTICYCLE_EN makes a multiply hold stage 1 for MUL_LAT cycles.
module pipe_scoreboard
    import pipe_sb_pkg::*;
#(
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4
) (
    input  logic     clk,
    input  logic     reset,
    pipe_sb_if.slave sb
);
    localparam int FSW = fsel_w(DEPTH);
    localparam logic [REG_AW-1:0] XZR = REG_AW'(XZR_IDX);

    if (DEPTH < 2 || DEPTH > 6 || MUL_LAT < 1) begin : g_bad_params
        $error("pipe_scoreboard: DEPTH must be 2..6 and MUL_LAT at least 1");
    end

    stage_meta_t [DEPTH-1:0]      meta_q;
    logic [DEPTH-1:0][REG_AW-1:0] rd_q;
    logic [NUM_SRC-1:0]           load_hit;
    logic [NUM_SRC*FSW-1:0]       fwd_sel;
    logic                         stall;
    logic                         flush;
    logic                         freeze;
    logic                         hold;
    stage_meta_t                  dec_meta;
    logic [REG_AW-1:0]            dec_rd;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_pick
        pipe_sb_fwd_pick #(
            .DEPTH  (DEPTH),
            .REG_AW (REG_AW),
            .FSW    (FSW)
        ) u_pick (
            .src      (sb.id_src[i*REG_AW +: REG_AW]),
            .used     (sb.id_src_used[i]),
            .meta     (meta_q),
            .rd       (rd_q),
            .sel      (fwd_sel[i*FSW +: FSW]),
            .load_hit (load_hit[i])
        );
    end

    // Stall beats a taken branch; decode re-presents the branch after the bubble.
    assign stall = (sb.id_valid && (|load_hit)) || freeze;
    assign flush = sb.id_valid && sb.br_taken && !stall;

    always_comb begin
        dec_meta = '0;
        dec_rd   = '0;
        if (sb.id_valid && !stall) begin
            dec_meta.valid    = 1'b1;
            dec_meta.regwrite = sb.id_regwrite;
            dec_meta.load     = sb.id_is_load;
            dec_meta.mul      = sb.id_is_mul;
            dec_rd            = sb.id_rd;
        end
    end

`ifdef PIPE_SB_MULTICYCLE_EN
    localparam int MCW = $clog2(MUL_LAT + 1);

    logic [MCW-1:0] mul_cnt;

    // The multiply sits in stage 1 while the counter drains, then moves on with the last count.
    assign freeze = (mul_cnt != '0);
    assign hold   = freeze && (mul_cnt != MCW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_cnt <= '0;
        end else if (freeze) begin
            mul_cnt <= mul_cnt - MCW'(1);
        end else if (dec_meta.valid && dec_meta.mul) begin
            mul_cnt <= MCW'(MUL_LAT - 1);
        end
    end
`else
    assign freeze = 1'b0;
    assign hold   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            rd_q   <= '0;
        end else begin
            if (!hold) begin
                meta_q[0] <= dec_meta;
                rd_q[0]   <= dec_rd;
            end
            meta_q[1] <= hold ? stage_meta_t'('0) : meta_q[0];
            rd_q[1]   <= hold ? '0 : rd_q[0];
            for (int k = 2; k < DEPTH; k++) begin
                meta_q[k] <= meta_q[k-1];
                rd_q[k]   <= rd_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb.stall_cnt <= '0;
            sb.flush_cnt <= '0;
        end else begin
            if (stall && (sb.stall_cnt != '1)) sb.stall_cnt <= sb.stall_cnt + 32'd1;
            if (flush && (sb.flush_cnt != '1)) sb.flush_cnt <= sb.flush_cnt + 32'd1;
        end
    end

    assign sb.stall    = stall;
    assign sb.flush_if = flush;
    assign sb.fwd_sel  = fwd_sel;
    assign sb.wb_valid = meta_q[DEPTH-1].valid && meta_q[DEPTH-1].regwrite && (rd_q[DEPTH-1] != XZR);
    assign sb.wb_rd    = rd_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: a vector table for the instruction stream plus
// hand sequences for reset-in-flight and multiply behaviour (PIPE_SB_MULTICYCLE_EN aware).
module tb_pipe_scoreboard;

    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       mul;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] used;
        logic       br;
        logic       e_stall;
        logic       e_flush;
        logic [1:0] e_f0;
        logic [1:0] e_f1;
        logic       e_wbv;
        logic [4:0] e_wbrd;
        int         e_scnt;
        int         e_fcnt;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    vec_t tbl [14];

    pipe_sb_if #(.DEPTH(3), .NUM_SRC(2), .REG_AW(5)) sb ();

    pipe_scoreboard #(
        .DEPTH   (3),
        .NUM_SRC (2),
        .REG_AW  (5),
        .MUL_LAT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int v, input int rd, input int rw, input int ld, input int mul,
                                input int s0, input int s1, input int used, input int br,
                                input int e_stall, input int e_flush, input int e_f0, input int e_f1,
                                input int e_wbv, input int e_wbrd, input int e_scnt, input int e_fcnt);
        vec_t t;
        t.v = 1'(v);   t.rd = 5'(rd);  t.rw = 1'(rw);  t.ld = 1'(ld);  t.mul = 1'(mul);
        t.s0 = 5'(s0); t.s1 = 5'(s1);  t.used = 2'(used); t.br = 1'(br);
        t.e_stall = 1'(e_stall); t.e_flush = 1'(e_flush);
        t.e_f0 = 2'(e_f0); t.e_f1 = 2'(e_f1);
        t.e_wbv = 1'(e_wbv); t.e_wbrd = 5'(e_wbrd);
        t.e_scnt = e_scnt; t.e_fcnt = e_fcnt;
        return t;
    endfunction

    function automatic vec_t ins(input int v, input int rd, input int rw, input int ld, input int mul,
                                 input int s0, input int s1, input int used, input int br);
        return mk(v, rd, rw, ld, mul, s0, s1, used, br, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic apply_stimulus(input vec_t t);
        sb.id_valid    = t.v;
        sb.id_rd       = t.rd;
        sb.id_regwrite = t.rw;
        sb.id_is_load  = t.ld;
        sb.id_is_mul   = t.mul;
        sb.id_src      = {t.s1, t.s0};
        sb.id_src_used = t.used;
        sb.br_taken    = t.br;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vector(input int idx, input vec_t t);
        check_output($sformatf("v%0d stall", idx),     32'(sb.stall),        32'(t.e_stall));
        check_output($sformatf("v%0d flush_if", idx),  32'(sb.flush_if),     32'(t.e_flush));
        check_output($sformatf("v%0d fwd_sel0", idx),  32'(sb.fwd_sel[1:0]), 32'(t.e_f0));
        check_output($sformatf("v%0d fwd_sel1", idx),  32'(sb.fwd_sel[3:2]), 32'(t.e_f1));
        check_output($sformatf("v%0d wb_valid", idx),  32'(sb.wb_valid),     32'(t.e_wbv));
        check_output($sformatf("v%0d wb_rd", idx),     32'(sb.wb_rd),        32'(t.e_wbrd));
        check_output($sformatf("v%0d stall_cnt", idx), sb.stall_cnt,         32'(t.e_scnt));
        check_output($sformatf("v%0d flush_cnt", idx), sb.flush_cnt,         32'(t.e_fcnt));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check_output({tag, " stall"},     32'(sb.stall),    32'd0);
        check_output({tag, " flush_if"},  32'(sb.flush_if), 32'd0);
        check_output({tag, " fwd_sel"},   32'(sb.fwd_sel),  32'd0);
        check_output({tag, " wb_valid"},  32'(sb.wb_valid), 32'd0);
        check_output({tag, " wb_rd"},     32'(sb.wb_rd),    32'd0);
        check_output({tag, " stall_cnt"}, sb.stall_cnt,     32'd0);
        check_output({tag, " flush_cnt"}, sb.flush_cnt,     32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        apply_stimulus(ins(0, 0, 0, 0, 0, 0, 0, 0, 0));

        //            v rd rw ld mu s0 s1 us br | st fl f0 f1 wbv wbrd scnt fcnt
        tbl[0]  = mk(1,  1, 1, 0, 0,  2, 3, 3, 0,  0, 0, 0, 0, 0,  0, 0, 0);
        tbl[1]  = mk(1,  2, 1, 0, 0,  1, 3, 3, 0,  0, 0, 1, 0, 0,  0, 0, 0);
        tbl[2]  = mk(1,  4, 1, 1, 0,  2, 1, 1, 0,  0, 0, 1, 0, 0,  0, 0, 0);
        tbl[3]  = mk(1,  5, 1, 0, 0,  4, 4, 3, 0,  1, 0, 0, 0, 1,  1, 0, 0);
        tbl[4]  = mk(1,  5, 1, 0, 0,  4, 4, 3, 0,  0, 0, 2, 2, 1,  2, 1, 0);
        tbl[5]  = mk(1, 31, 1, 0, 0,  5, 4, 3, 0,  0, 0, 1, 3, 1,  4, 1, 0);
        tbl[6]  = mk(1,  6, 1, 0, 0, 31,31, 3, 0,  0, 0, 0, 0, 0,  0, 1, 0);
        tbl[7]  = mk(1,  0, 0, 0, 0,  6, 0, 1, 1,  0, 1, 1, 0, 1,  5, 1, 0);
        tbl[8]  = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 31, 1, 1);
        tbl[9]  = mk(0,  0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0, 1,  6, 1, 1);
        tbl[10] = mk(1,  8, 1, 1, 0,  2, 0, 1, 0,  0, 0, 0, 0, 0,  0, 1, 1);
        tbl[11] = mk(1,  0, 0, 0, 0,  8, 0, 1, 1,  1, 0, 0, 0, 0,  0, 1, 1);
        tbl[12] = mk(1,  0, 0, 0, 0,  8, 0, 1, 1,  0, 1, 2, 0, 0,  0, 2, 1);
        tbl[13] = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1,  8, 2, 2);

        #3;
        check_cleared("reset");
        step();
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(tbl[i]);
            #1;
            check_vector(i, tbl[i]);
            step();
        end

        // Reset pulsed while a load-use stall is showing.
        apply_stimulus(ins(1, 4, 1, 1, 0, 0, 0, 0, 0));
        #1;
        check_output("seqA ldur stall", 32'(sb.stall), 32'd0);
        step();
        apply_stimulus(ins(1, 5, 1, 0, 0, 4, 0, 1, 0));
        #1;
        check_output("seqA use stall",     32'(sb.stall), 32'd1);
        check_output("seqA use stall_cnt", sb.stall_cnt,  32'd2);
        reset = 1'b0;
        #1;
        check_cleared("seqA in reset");
        reset = 1'b1;
        #1;
        check_output("seqA released stall", 32'(sb.stall), 32'd0);
        step();
        apply_stimulus(ins(0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check_output("seqA after stall",     32'(sb.stall), 32'd0);
        check_output("seqA after stall_cnt", sb.stall_cnt,  32'd0);
        step();

`ifdef PIPE_SB_MULTICYCLE_EN
        apply_stimulus(ins(1, 6, 1, 0, 1, 0, 0, 0, 0));
        #1;
        check_output("mul issue stall", 32'(sb.stall), 32'd0);
        step();
        apply_stimulus(ins(1, 7, 1, 0, 0, 6, 0, 1, 0));
        for (int k = 0; k < 3; k++) begin
            #1;
            check_output($sformatf("mul frozen%0d stall", k), 32'(sb.stall), 32'd1);
            check_output($sformatf("mul frozen%0d fwd0", k),  32'(sb.fwd_sel[1:0]), 32'd0);
            step();
        end
        #1;
        check_output("mul done stall",     32'(sb.stall),        32'd0);
        check_output("mul done fwd0",      32'(sb.fwd_sel[1:0]), 32'd2);
        check_output("mul done stall_cnt", sb.stall_cnt,         32'd3);
        step();
        apply_stimulus(ins(1, 9, 1, 0, 1, 0, 0, 0, 0));
        #1;
        check_output("mul2 issue stall", 32'(sb.stall), 32'd0);
        step();
        apply_stimulus(ins(1, 10, 1, 0, 0, 9, 0, 1, 0));
        #1;
        check_output("mul2 frozen0 stall", 32'(sb.stall), 32'd1);
        step();
        #1;
        check_output("mul2 frozen1 stall",     32'(sb.stall), 32'd1);
        check_output("mul2 frozen1 stall_cnt", sb.stall_cnt,  32'd4);
        reset = 1'b0;
        #1;
        check_cleared("mul2 in reset");
        reset = 1'b1;
        #1;
        check_output("mul2 released stall", 32'(sb.stall), 32'd0);
        step();
        check_output("mul2 next stall", 32'(sb.stall), 32'd0);
`else
        apply_stimulus(ins(1, 6, 1, 0, 1, 0, 0, 0, 0));
        #1;
        check_output("mul issue stall", 32'(sb.stall), 32'd0);
        step();
        apply_stimulus(ins(1, 7, 1, 0, 0, 6, 0, 1, 0));
        #1;
        check_output("mul s1 stall", 32'(sb.stall),        32'd0);
        check_output("mul s1 fwd0",  32'(sb.fwd_sel[1:0]), 32'd0);
        step();
        apply_stimulus(ins(1, 8, 1, 0, 0, 6, 0, 1, 0));
        #1;
        check_output("mul s2 stall",     32'(sb.stall),        32'd0);
        check_output("mul s2 fwd0",      32'(sb.fwd_sel[1:0]), 32'd2);
        check_output("mul s2 stall_cnt", sb.stall_cnt,         32'd0);
`endif

        apply_stimulus(ins(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
